// File: rtl/ms_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : ms_alu_sequencer
//  Summary  : Control sequencer for the multi-step ALU. Accepts one 10-bit
//             instruction per Run handshake, drives OP/ALUControl/Ain/Gin/
//             Gout and owns an 8 x DATA_W register file written from Q.
//  Options  : MSSEQ_ZFLAG_EN adds a Zero flag output, updated on every ALU
//             and MV writeback.
//  Revision : 1.0 - initial release
// ============================================================================
module ms_alu_sequencer #(
  parameter int DATA_W = 10,
  parameter int NREGS  = 8
) (
  input  logic              CLKb,
  input  logic              Reset,
  input  logic              Run,
  input  logic [DATA_W-1:0] Din,
  input  logic [DATA_W-1:0] Q,
  input  logic [2:0]        RdSel,
  output logic [DATA_W-1:0] OP,
  output logic [2:0]        ALUControl,
  output logic              Ain,
  output logic              Gin,
  output logic              Gout,
  output logic              Busy,
  output logic              Done,
`ifdef MSSEQ_ZFLAG_EN
  output logic              Zero,
`endif
  output logic [DATA_W-1:0] RdData
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_MOVE = 3'd4,
    S_IMM  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [2:0] c_OPC_MV  = 3'b110;
  localparam logic [2:0] c_OPC_MVI = 3'b111;

  state_t            r_state;
  state_t            w_next;

  // Instruction register, kept as decoded fields (IR[0] carries no meaning)
  logic [2:0]        r_opc;
  logic [2:0]        r_rx;
  logic [2:0]        r_ry;
  logic [2:0]        r_aluctl;
  logic [DATA_W-1:0] r_regs [NREGS];

  logic              w_we;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rx_val;
  logic [DATA_W-1:0] w_ry_val;

  assign w_rx_val   = r_regs[r_rx];
  assign w_ry_val   = r_regs[r_ry];
  assign RdData     = r_regs[RdSel];
  assign ALUControl = r_aluctl;

  // State register
  always_ff @(posedge CLKb) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode and Moore strobes derived from the current state
  always_comb begin
    w_next  = r_state;
    Ain     = 1'b0;
    Gin     = 1'b0;
    Gout    = 1'b0;
    Done    = 1'b0;
    Busy    = 1'b1;
    OP      = '0;
    w_we    = 1'b0;
    w_wdata = '0;
    case (r_state)
      S_IDLE: begin
        Busy = 1'b0;
        if (Run) begin
          if (Din[9:7] == c_OPC_MV) begin
            w_next = S_MOVE;
          end else if (Din[9:7] == c_OPC_MVI) begin
            w_next = S_IMM;
          end else begin
            w_next = S_T1;
          end
        end
      end
      S_T1: begin
        Ain    = 1'b1;
        OP     = w_rx_val;
        w_next = S_T2;
      end
      S_T2: begin
        Gin    = 1'b1;
        OP     = w_ry_val;
        w_next = S_T3;
      end
      S_T3: begin
        Gout    = 1'b1;
        w_we    = 1'b1;
        w_wdata = Q;
        w_next  = S_DONE;
      end
      S_MOVE: begin
        w_we    = 1'b1;
        w_wdata = w_ry_val;
        w_next  = S_DONE;
      end
      S_IMM: begin
        w_we    = 1'b1;
        w_wdata = Din;
        w_next  = S_DONE;
      end
      S_DONE: begin
        Done   = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Instruction latch, ALU function register and register-file writeback.
  // ALUControl is loaded on the T1->T2 edge so it is valid throughout T2
  // and simply holds afterwards.
  always_ff @(posedge CLKb) begin
    if (Reset) begin
      r_opc    <= '0;
      r_rx     <= '0;
      r_ry     <= '0;
      r_aluctl <= '0;
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      if (r_state == S_IDLE && Run) begin
        r_opc <= Din[9:7];
        r_rx  <= Din[6:4];
        r_ry  <= Din[3:1];
      end
      if (r_state == S_T1) begin
        r_aluctl <= r_opc;
      end
      if (w_we) begin
        r_regs[r_rx] <= w_wdata;
      end
    end
  end

`ifdef MSSEQ_ZFLAG_EN
  logic r_zero;
  assign Zero = r_zero;

  // Zero tracks ALU and MV writebacks only; MVI leaves it untouched
  always_ff @(posedge CLKb) begin
    if (Reset) begin
      r_zero <= 1'b0;
    end else if (r_state == S_T3 || r_state == S_MOVE) begin
      r_zero <= (w_wdata == '0);
    end
  end
`endif

endmodule
`default_nettype wire
